// File: rtl/lab61soc_input_debounce.sv
// Input conditioner for the switch PIO: per-bit 2-flop synchroniser, shared
// sample-tick prescaler and per-bit stability counter, plus registered
// rise/fall event pulses and a combined "changed" strobe.

// One debounce channel: owns its stability counter, clean level and pulses.
module lab61soc_input_debounce_lane #(
   parameter int STABLE_TICKS = 10,
   parameter int CW           = 4,
   parameter bit INIT         = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_tick,
   input  logic i_enable,
   input  logic i_sync,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_evt_nxt
);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic          r_level, r_rise, r_fall;
   logic [CW-1:0] r_cnt;
   logic          w_level_nxt, w_rise_nxt, w_fall_nxt;
   logic [CW-1:0] w_cnt_nxt;

   // Next level/count: agreement always clears the count, so a glitch back restarts it.
   always_comb begin
      w_level_nxt = r_level;
      w_cnt_nxt   = r_cnt;
      if (!i_enable) begin
         w_level_nxt = i_sync;
         w_cnt_nxt   = '0;
      end else if (i_sync == r_level) begin
         w_cnt_nxt   = '0;
      end else if (i_tick && (r_cnt == LAST)) begin
         w_level_nxt = i_sync;
         w_cnt_nxt   = '0;
      end else if (i_tick) begin
         w_cnt_nxt   = r_cnt + 1'b1;
      end
      w_rise_nxt = w_level_nxt & ~r_level;
      w_fall_nxt = ~w_level_nxt & r_level;
   end

   // Level, counter and pulses share one edge so a pulse marks the first cycle of the new level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_level <= INIT;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_level <= w_level_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   assign o_level   = r_level;
   assign o_rise    = r_rise;
   assign o_fall    = r_fall;
   assign o_evt_nxt = w_rise_nxt | w_fall_nxt;
endmodule

module lab61soc_input_debounce #(
   parameter int WIDTH        = 8,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10,
   parameter int INIT_LEVEL   = 0,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_in,
   input  logic             enable,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             changed
);
   localparam int         PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int         CW   = $clog2(STABLE_TICKS + 1);
   localparam logic       INIT = (INIT_LEVEL != 0);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [WIDTH-1:0] w_pol, w_evt_nxt;
   logic [WIDTH-1:0] r_sync1, r_sync2;
   logic [PW-1:0]    r_pre;
   logic             w_tick;
   logic             r_changed;

   assign w_pol  = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;
   assign w_tick = (r_pre == PRE_LAST);

   // Two-flop synchroniser; only r_sync2 feeds the debounce logic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= {WIDTH{INIT}};
         r_sync2 <= {WIDTH{INIT}};
      end else begin
         r_sync1 <= w_pol;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running sample prescaler, keeps counting even in bypass.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pre <= '0;
      else          r_pre <= w_tick ? '0 : r_pre + 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_lane
         lab61soc_input_debounce_lane #(
            .STABLE_TICKS (STABLE_TICKS),
            .CW           (CW),
            .INIT         (INIT)
         ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_tick    (w_tick),
            .i_enable  (enable),
            .i_sync    (r_sync2[gi]),
            .o_level   (out_port[gi]),
            .o_rise    (rise_pulse[gi]),
            .o_fall    (fall_pulse[gi]),
            .o_evt_nxt (w_evt_nxt[gi])
         );
      end
   endgenerate

   // Single strobe for any channel event, aligned with the per-bit pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_changed <= 1'b0;
      else          r_changed <= |w_evt_nxt;
   end

   assign changed = r_changed;
endmodule

// File: tb/tb_lab61soc_input_debounce.sv
// Bench: unit A (TICK_DIV=1, STABLE_TICKS=4) and unit B (TICK_DIV=5,
// STABLE_TICKS=2) run against a tick-counting model every cycle, plus
// hand-computed literal checks of the scenario timings.
module tb_lab61soc_input_debounce;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] raw_a, raw_b;
   logic       en_a, en_b;
   logic [7:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
   logic       chg_a, chg_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lab61soc_input_debounce #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(4),
      .INIT_LEVEL(0), .ACTIVE_LOW(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_a), .enable(en_a),
      .out_port(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
      .changed(chg_a));

   lab61soc_input_debounce #(.WIDTH(8), .TICK_DIV(5), .STABLE_TICKS(2),
      .INIT_LEVEL(0), .ACTIVE_LOW(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_b), .enable(en_b),
      .out_port(out_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
      .changed(chg_b));

   // ---------------- model ----------------
   // Each bit remembers the global tick count at which its current
   // disagreement run began; the level flips once STABLE_TICKS ticks
   // have elapsed inside that run.
   logic [7:0] m_s1[2], m_s2[2], m_out[2], m_rise[2], m_fall[2];
   logic       m_chg[2];
   int         m_edges[2], m_ticks[2];
   int         dis_from[2][8];

   function automatic int td(input int u);
      return (u == 0) ? 1 : 5;
   endfunction
   function automatic int st(input int u);
      return (u == 0) ? 4 : 2;
   endfunction

   task automatic model_reset(input int u);
      m_s1[u] = 8'h00; m_s2[u] = 8'h00; m_out[u] = 8'h00;
      m_rise[u] = 8'h00; m_fall[u] = 8'h00; m_chg[u] = 1'b0;
      m_edges[u] = 0; m_ticks[u] = 0;
      for (int i = 0; i < 8; i++) dis_from[u][i] = -1;
   endtask

   task automatic model_step(input int u, input logic [7:0] raw, input logic en);
      logic       tick;
      logic [7:0] nout;
      tick = ((m_edges[u] % td(u)) == td(u) - 1);
      nout = m_out[u];
      for (int i = 0; i < 8; i++) begin
         if (!en) begin
            nout[i] = m_s2[u][i];
            dis_from[u][i] = -1;
         end else if (m_s2[u][i] == m_out[u][i]) begin
            dis_from[u][i] = -1;
         end else begin
            if (dis_from[u][i] < 0) dis_from[u][i] = m_ticks[u];
            if (tick && (m_ticks[u] + 1 - dis_from[u][i] == st(u))) begin
               nout[i] = m_s2[u][i];
               dis_from[u][i] = -1;
            end
         end
      end
      m_rise[u] = nout & ~m_out[u];
      m_fall[u] = ~nout & m_out[u];
      m_chg[u]  = |(m_rise[u] | m_fall[u]);
      m_out[u]  = nout;
      m_s2[u]   = m_s1[u];
      m_s1[u]   = raw;
      if (tick) m_ticks[u]++;
      m_edges[u]++;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, raw_a, en_a);
         model_step(1, raw_b, en_b);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("a.out",  out_a,  m_out[0]);
      chk("a.rise", rise_a, m_rise[0]);
      chk("a.fall", fall_a, m_fall[0]);
      chk("a.chg",  {7'd0, chg_a}, {7'd0, m_chg[0]});
      chk("b.out",  out_b,  m_out[1]);
      chk("b.rise", rise_b, m_rise[1]);
      chk("b.fall", fall_b, m_fall[1]);
      chk("b.chg",  {7'd0, chg_b}, {7'd0, m_chg[1]});
   end

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed stimulus ----------------
   int lat_exp[5] = '{10, 9, 8, 12, 11};
   logic [7:0] bounce[4] = '{8'h03, 8'h03, 8'h03, 8'h01};

   initial begin
      int lat;
      bit got;
      reset_n = 1'b0; raw_a = 8'hFF; raw_b = 8'h00; en_a = 1'b1; en_b = 1'b1;
      wait_edges(3);
      chk("rst.out", out_a, 8'h00);
      chk("rst.rise", rise_a, 8'h00);
      reset_n = 1'b1;
      wait_edges(5);
      chk("rel.out5", out_a, 8'h00);
      wait_edges(1);
      chk("rel.out6", out_a, 8'hFF);
      chk("rel.rise6", rise_a, 8'hFF);
      chk("rel.chg6", {7'd0, chg_a}, 8'h01);
      wait_edges(1);
      chk("rel.rise7", rise_a, 8'h00);

      // clean single-bit step
      raw_a = 8'h00; wait_edges(10);
      raw_a = 8'h01; wait_edges(5);
      chk("step.out5", out_a, 8'h00);
      wait_edges(1);
      chk("step.out6", out_a, 8'h01);
      chk("step.rise6", rise_a, 8'h01);
      chk("step.chg6", {7'd0, chg_a}, 8'h01);
      wait_edges(1);
      chk("step.rise7", rise_a, 8'h00);
      chk("step.chg7", {7'd0, chg_a}, 8'h00);

      // bounce on bit 1, then settle high
      for (int k = 0; k < 4; k++) begin
         raw_a = bounce[k]; wait_edges(1);
      end
      raw_a = 8'h03; wait_edges(5);
      chk("bnc.out5", out_a, 8'h01);
      wait_edges(1);
      chk("bnc.out6", out_a, 8'h03);
      chk("bnc.rise6", rise_a, 8'h02);

      // all bits fall together
      raw_a = 8'hFF; wait_edges(10);
      raw_a = 8'h00; wait_edges(5);
      chk("sim.out5", out_a, 8'hFF);
      wait_edges(1);
      chk("sim.out6", out_a, 8'h00);
      chk("sim.fall6", fall_a, 8'hFF);
      chk("sim.chg6", {7'd0, chg_a}, 8'h01);
      wait_edges(1);
      chk("sim.fall7", fall_a, 8'h00);
      chk("sim.chg7", {7'd0, chg_a}, 8'h00);

      // bypass
      en_a = 1'b0; wait_edges(2);
      raw_a = 8'h04; wait_edges(2);
      chk("byp.out2", out_a, 8'h00);
      wait_edges(1);
      chk("byp.out3", out_a, 8'h04);
      chk("byp.rise3", rise_a, 8'h04);
      wait_edges(1);
      en_a = 1'b1; raw_a = 8'h00; wait_edges(10);

      // reset while bit 3 is part-way through its count
      raw_a = 8'h30; wait_edges(10);
      chk("mrst.pre", out_a, 8'h30);
      raw_a = 8'h38; wait_edges(4);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst.out", out_a, 8'h00);
      chk("mrst.rise", rise_a, 8'h00);
      chk("mrst.fall", fall_a, 8'h00);
      chk("mrst.chg", {7'd0, chg_a}, 8'h00);
      wait_edges(2);
      reset_n = 1'b1;
      wait_edges(5);
      chk("mrst.out5", out_a, 8'h00);
      wait_edges(1);
      chk("mrst.out6", out_a, 8'h38);
      chk("mrst.rise6", rise_a, 8'h38);

      // prescaler phase sweep on unit B
      for (int p = 0; p < 5; p++) begin
         raw_b = 8'h00; wait_edges(20);
         for (int k = 0; k < 5 && (m_edges[1] % 5) != p; k++) @(negedge clk);
         raw_b = 8'h01;
         lat = 99; got = 1'b0;
         for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (out_b[0]) begin lat = k; got = 1'b1; end
         end
         chk($sformatf("pre.lat%0d", p), 8'(lat), 8'(lat_exp[p]));
      end
      raw_b = 8'h00; wait_edges(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
